imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader directly upstream of the instruction-fetch stage.
- Receives a byte stream from the UART receiver, assembles 32-bit big-endian words and writes them into the instruction memory (prgrom write port).
- While loading, holds the CPU (fetch PC) in reset. Otherwise it passes the fetch stage's word address through to the memory unchanged.

Parameters:
- ADDR_W, 14, instruction-memory word-address width; matches fetch PC[15:2].
- DEPTH, 16384, instruction-memory capacity in words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start_pg  in  1  level/pulse; request to enter program-load mode.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle.
- rx_byte  in  8  received UART byte.
- fetch_addr  in  ADDR_W  word address from the fetch stage (PC[15:2]).
- mem_addr  out  ADDR_W  address to instruction memory (muxed).
- mem_wdata  out  32  assembled instruction word.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- cpu_hold  out  1  forces fetch/CPU reset while high.
- load_done  out  1  high after a successful load until the next start_pg or reset.
- load_err  out  1  high in ERR until the next start_pg or reset.
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset values: state=IDLE, mem_we=0, mem_wdata=0, cpu_hold=0, load_done=0, load_err=0, word_count=0, byte index=0.
- Stream format: 2-byte header N (high byte first), then N words of 4 bytes each, first byte → wdata[31:24].
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, DONE, ERR (plus CHK with the optional feature).
- IDLE/DONE/ERR + start_pg=1 → HDR_HI. Clear word_count, byte index, load_done, load_err.
- In HDR_HI, HDR_LO, DATA and CHK, start_pg is ignored.
- HDR_HI + rx_valid → latch N[15:8] → HDR_LO.
- HDR_LO + rx_valid → latch N[7:0]. Then:
  - N=0 → DONE.
  - N>DEPTH → ERR.
  - otherwise → DATA.
- DATA, word assembly:
  - Each rx_valid shifts the byte into the word and increments the byte index (0..3, wraps).
  - On the 4th byte, the next cycle has mem_we=1 for exactly one cycle, mem_addr=word_count[ADDR_W-1:0] (pre-increment) and mem_wdata=the full word. word_count increments on that same edge.
  - After the N-th write → DONE.
- Bytes arriving with no rx_valid are ignored. A rx_valid coincident with the mem_we cycle must still be accepted (back-to-back bytes, 1 byte/cycle max).
- cpu_hold=1 in HDR_HI, HDR_LO, DATA, CHK and ERR; 0 in IDLE and DONE.
- mem_addr = fetch_addr when cpu_hold=0. When cpu_hold=1 it is the load address (word_count), driven combinationally from state.
- load_done=1 only in DONE. load_err=1 only in ERR.
- Reset mid-load: abort immediately to IDLE. Already-written words remain in memory, no further writes, cpu_hold drops on the cycle after reset is sampled.
- Once the header has been taken, no timeout: the loader waits indefinitely for bytes.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An XOR accumulator over all data bytes is cleared at HDR_HI entry.
  - After the N-th word, DATA → CHK (also HDR_LO → CHK when N=0, comparing against 0x00).
  - CHK + rx_valid: byte == accumulator → DONE, else → ERR.
- Undefined: no CHK state, no accumulator. DATA → DONE directly.

Decomposition:
- Shared package: FSM state encoding constants (IDLE..CHK), header byte count (2), bytes per word (4), default ADDR_W/DEPTH.
- One natural sub-module, imem_word_packer: byte shift register, byte index counter, word-ready strobe. The FSM and address mux stay in the top.

Test Plan:
- Reset, then fetch_addr=0x0123 → mem_addr=0x0123, cpu_hold=0, mem_we=0, word_count=0.
- start_pg, bytes 00 02 | 3C 01 00 10 | 8C 22 00 04 → two mem_we pulses:
  - addr 0, data 0x3C010010
  - addr 1, data 0x8C220004
  - then load_done=1, cpu_hold=0, word_count=2.
- Header 00 00 → immediately DONE, no mem_we, word_count=0.
- Header 40 01 (N=16385 > DEPTH) → ERR, load_err=1, cpu_hold=1, no writes. A following start_pg → HDR_HI with load_err cleared.
- Mid-load reset after 5 data bytes → one word written at addr 0. After reset: IDLE, cpu_hold=0, no further mem_we, mem_addr tracks fetch_addr.
- With IMEM_LOADER_CHECKSUM_EN: header 00 01, data 12 34 56 78, checksum 0x08 → DONE. With checksum 0x09 → ERR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN (enables the CHK state).
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_ADDR_W = 14;
    localparam int DEFAULT_DEPTH  = 16384;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5,
        ST_CHK    = 3'd6
    } state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream and emits a
// one-cycle word_valid strobe the cycle after the 4th byte arrives.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;

    // Shift incoming bytes in MSB-first; capture the full word on the last byte.
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (clear) begin
            idx_d = 2'd0;
        end else if (byte_en) begin
            shift_d = {shift_q[15:0], byte_in};
            if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
                idx_d   = 2'd0;
                word_d  = {shift_q, byte_in};
                valid_d = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: header N (2 bytes, MSB first) followed by N
// big-endian words, written into instruction memory while the CPU is held.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte verified in the CHK state.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_pg,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    state_e          state_q, state_d;
    logic [15:0]     n_q, n_d;
    logic [ADDR_W:0] wc_q, wc_d;
    logic [15:0]     hdr_n;
    logic            packer_en;
    logic            packer_clear;
    logic            word_valid;
    logic [31:0]     words_seen;
    logic            last_write;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      acc_q, acc_d;
`endif

    assign hdr_n = {n_q[15:8], rx_byte};

    // Words already assembled (written or pending write); stop accepting
    // data bytes once all N words are in, so trailing bytes never corrupt
    // the packer.
    assign words_seen = 32'(wc_q) + {31'd0, word_valid};
    assign packer_en  = rx_valid && (state_q == ST_DATA) && (words_seen < 32'(n_q));
    assign last_write = word_valid && ((32'(wc_q) + 32'd1) == 32'(n_q));

    imem_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (packer_clear),
        .byte_en    (packer_en),
        .byte_in    (rx_byte),
        .word       (mem_wdata),
        .word_valid (word_valid)
    );

    // Next-state logic for the load FSM, header latch and word counter.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        wc_d         = wc_q;
        packer_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_d        = acc_q;
`endif
        if (word_valid) begin
            wc_d = wc_q + 1'b1;
        end
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_pg) begin
                    state_d      = ST_HDR_HI;
                    wc_d         = '0;
                    packer_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    acc_d        = 8'h00;
`endif
                end
            end
            ST_HDR_HI: begin
                if (rx_valid) begin
                    n_d[15:8] = rx_byte;
                    state_d   = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (rx_valid) begin
                    n_d = hdr_n;
                    if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else if (32'(hdr_n) > 32'(DEPTH)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (packer_en) begin
                    acc_d = acc_q ^ rx_byte;
                end
                // A checksum byte may arrive in the same cycle as the final write.
                if (last_write) begin
                    if (rx_valid) begin
                        state_d = (rx_byte == acc_q) ? ST_DONE : ST_ERR;
                    end else begin
                        state_d = ST_CHK;
                    end
                end
`else
                if (last_write) begin
                    state_d = ST_DONE;
                end
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (rx_valid) begin
                    state_d = (rx_byte == acc_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            wc_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wc_q    <= wc_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // Outputs decoded from state; address muxed between loader and fetch.
    always_comb begin
        cpu_hold  = !((state_q == ST_IDLE) || (state_q == ST_DONE));
        load_done = (state_q == ST_DONE);
        load_err  = (state_q == ST_ERR);
        mem_addr  = cpu_hold ? wc_q[ADDR_W-1:0] : fetch_addr;
    end

    assign mem_we     = word_valid;
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 14;
    localparam logic [13:0] F = 14'h0123;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start_pg = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte = 8'h00;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(16384)) dut (
        .clock      (clock),
        .reset      (reset),
        .start_pg   (start_pg),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .fetch_addr (fetch_addr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        start;
        logic        rxv;
        logic [7:0]  rxb;
        logic [13:0] fa;
        logic        we;
        logic [13:0] addr;
        logic        chkwd;
        logic [31:0] wd;
        logic        hold;
        logic        done;
        logic        err;
        logic [14:0] wc;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_miscompares = 0;

    function automatic void add(logic rst, logic start, logic rxv, logic [7:0] rxb,
                                logic [13:0] fa, logic we, logic [13:0] addr,
                                logic chkwd, logic [31:0] wd, logic hold,
                                logic done, logic err, logic [14:0] wc);
        vec_t v;
        v.rst = rst; v.start = start; v.rxv = rxv; v.rxb = rxb; v.fa = fa;
        v.we = we; v.addr = addr; v.chkwd = chkwd; v.wd = wd; v.hold = hold;
        v.done = done; v.err = err; v.wc = wc;
        vecs.push_back(v);
    endfunction

    function automatic void add_byte(logic [7:0] b, logic [13:0] addr, logic [14:0] wc);
        add(0, 0, 1, b, F, 0, addr, 0, 32'h0, 1, 0, 0, wc);
    endfunction

    task automatic drive(logic rst, logic start, logic rxv, logic [7:0] rxb, logic [13:0] fa);
        @(negedge clock);
        reset      = rst;
        start_pg   = start;
        rx_valid   = rxv;
        rx_byte    = rxb;
        fetch_addr = fa;
        @(posedge clock);
        #1;
    endtask

    initial begin
        add(1, 0, 0, 8'h00, F, 0, F, 1, 32'h0, 0, 0, 0, 15'd0);
        add(1, 0, 0, 8'h00, F, 0, F, 1, 32'h0, 0, 0, 0, 15'd0);
        add(0, 0, 0, 8'h00, F, 0, F, 1, 32'h0, 0, 0, 0, 15'd0);
        add(0, 1, 0, 8'h00, F, 0, 14'd0, 0, 32'h0, 1, 0, 0, 15'd0);
        add_byte(8'h00, 14'd0, 15'd0);
        add_byte(8'h02, 14'd0, 15'd0);
        add_byte(8'h3C, 14'd0, 15'd0);
        add(0, 1, 1, 8'h01, F, 0, 14'd0, 0, 32'h0, 1, 0, 0, 15'd0);
        add_byte(8'h00, 14'd0, 15'd0);
        add(0, 0, 1, 8'h10, F, 1, 14'd0, 1, 32'h3C010010, 1, 0, 0, 15'd0);
        add_byte(8'h8C, 14'd1, 15'd1);
        add_byte(8'h22, 14'd1, 15'd1);
        add_byte(8'h00, 14'd1, 15'd1);
        add(0, 0, 1, 8'h04, F, 1, 14'd1, 1, 32'h8C220004, 1, 0, 0, 15'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        add(0, 0, 0, 8'h00, F, 0, 14'd2, 0, 32'h0, 1, 0, 0, 15'd2);
        add(0, 0, 1, 8'h87, F, 0, F, 0, 32'h0, 0, 1, 0, 15'd2);
`else
        add(0, 0, 0, 8'h00, F, 0, F, 0, 32'h0, 0, 1, 0, 15'd2);
`endif
        add(0, 0, 0, 8'h00, 14'h3FFF, 0, 14'h3FFF, 0, 32'h0, 0, 1, 0, 15'd2);
        add(0, 1, 0, 8'h00, F, 0, 14'd0, 0, 32'h0, 1, 0, 0, 15'd0);
        add_byte(8'h00, 14'd0, 15'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        add_byte(8'h00, 14'd0, 15'd0);
        add(0, 0, 1, 8'h00, F, 0, F, 0, 32'h0, 0, 1, 0, 15'd0);
`else
        add(0, 0, 1, 8'h00, F, 0, F, 0, 32'h0, 0, 1, 0, 15'd0);
`endif
        add(0, 1, 0, 8'h00, F, 0, 14'd0, 0, 32'h0, 1, 0, 0, 15'd0);
        add_byte(8'h40, 14'd0, 15'd0);
        add(0, 0, 1, 8'h01, F, 0, 14'd0, 0, 32'h0, 1, 0, 1, 15'd0);
        add(0, 0, 1, 8'h3C, F, 0, 14'd0, 0, 32'h0, 1, 0, 1, 15'd0);
        add(0, 0, 1, 8'h01, F, 0, 14'd0, 0, 32'h0, 1, 0, 1, 15'd0);
        add(0, 1, 0, 8'h00, F, 0, 14'd0, 0, 32'h0, 1, 0, 0, 15'd0);
        add_byte(8'h40, 14'd0, 15'd0);
        add_byte(8'h00, 14'd0, 15'd0);
        add(1, 0, 0, 8'h00, F, 0, F, 1, 32'h0, 0, 0, 0, 15'd0);
        add(0, 1, 0, 8'h00, F, 0, 14'd0, 0, 32'h0, 1, 0, 0, 15'd0);
        add_byte(8'h00, 14'd0, 15'd0);
        add_byte(8'h05, 14'd0, 15'd0);
        add_byte(8'hAA, 14'd0, 15'd0);
        add_byte(8'hBB, 14'd0, 15'd0);
        add_byte(8'hCC, 14'd0, 15'd0);
        add(0, 0, 1, 8'hDD, F, 1, 14'd0, 1, 32'hAABBCCDD, 1, 0, 0, 15'd0);
        add_byte(8'hEE, 14'd1, 15'd1);
        add(1, 0, 1, 8'hFF, 14'h0010, 0, 14'h0010, 1, 32'h0, 0, 0, 0, 15'd0);
        add(0, 0, 1, 8'h11, 14'h0011, 0, 14'h0011, 0, 32'h0, 0, 0, 0, 15'd0);
        add(0, 0, 1, 8'h22, 14'h0012, 0, 14'h0012, 0, 32'h0, 0, 0, 0, 15'd0);
        add(0, 0, 1, 8'h33, 14'h0013, 0, 14'h0013, 0, 32'h0, 0, 0, 0, 15'd0);
        add(0, 0, 1, 8'h44, 14'h0014, 0, 14'h0014, 0, 32'h0, 0, 0, 0, 15'd0);
        add(0, 0, 0, 8'h00, 14'h0015, 0, 14'h0015, 0, 32'h0, 0, 0, 0, 15'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        add(0, 1, 0, 8'h00, F, 0, 14'd0, 0, 32'h0, 1, 0, 0, 15'd0);
        add_byte(8'h00, 14'd0, 15'd0);
        add_byte(8'h01, 14'd0, 15'd0);
        add_byte(8'h12, 14'd0, 15'd0);
        add_byte(8'h34, 14'd0, 15'd0);
        add_byte(8'h56, 14'd0, 15'd0);
        add(0, 0, 1, 8'h78, F, 1, 14'd0, 1, 32'h12345678, 1, 0, 0, 15'd0);
        add(0, 0, 0, 8'h00, F, 0, 14'd1, 0, 32'h0, 1, 0, 0, 15'd1);
        add(0, 0, 1, 8'h08, F, 0, F, 0, 32'h0, 0, 1, 0, 15'd1);
        add(0, 1, 0, 8'h00, F, 0, 14'd0, 0, 32'h0, 1, 0, 0, 15'd0);
        add_byte(8'h00, 14'd0, 15'd0);
        add_byte(8'h01, 14'd0, 15'd0);
        add_byte(8'h12, 14'd0, 15'd0);
        add_byte(8'h34, 14'd0, 15'd0);
        add_byte(8'h56, 14'd0, 15'd0);
        add(0, 0, 1, 8'h78, F, 1, 14'd0, 1, 32'h12345678, 1, 0, 0, 15'd0);
        add(0, 0, 1, 8'h09, F, 0, 14'd1, 0, 32'h0, 1, 0, 1, 15'd1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            reset      = vecs[i].rst;
            start_pg   = vecs[i].start;
            rx_valid   = vecs[i].rxv;
            rx_byte    = vecs[i].rxb;
            fetch_addr = vecs[i].fa;
            @(posedge clock);
            #1;
            n_applied++;
            if (mem_we !== vecs[i].we || mem_addr !== vecs[i].addr ||
                cpu_hold !== vecs[i].hold || load_done !== vecs[i].done ||
                load_err !== vecs[i].err || word_count !== vecs[i].wc ||
                (vecs[i].chkwd && mem_wdata !== vecs[i].wd)) begin
                n_miscompares++;
                $display("FAIL vec %0d: got we=%b addr=%h wd=%h hold=%b done=%b err=%b wc=%0d; want we=%b addr=%h wd=%h(chk=%b) hold=%b done=%b err=%b wc=%0d",
                         i, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, word_count,
                         vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].chkwd, vecs[i].hold,
                         vecs[i].done, vecs[i].err, vecs[i].wc);
            end else begin
                $display("vec %0d ok: we=%b addr=%h hold=%b done=%b err=%b wc=%0d",
                         i, mem_we, mem_addr, cpu_hold, load_done, load_err, word_count);
            end
        end

        drive(1, 0, 0, 8'h00, F);
        drive(0, 0, 0, 8'h00, F);
        n_applied++;
        if (mem_addr !== F || cpu_hold !== 1'b0 || mem_we !== 1'b0 ||
            word_count !== 15'd0 || load_done !== 1'b0 || load_err !== 1'b0) begin
            n_miscompares++;
            $display("FAIL reset-state: addr=%h hold=%b we=%b wc=%0d done=%b err=%b",
                     mem_addr, cpu_hold, mem_we, word_count, load_done, load_err);
        end else begin
            $display("reset-state ok: addr=%h hold=%b we=%b wc=%0d", mem_addr, cpu_hold, mem_we, word_count);
        end

        drive(0, 1, 0, 8'h00, F);
        drive(0, 0, 1, 8'h00, F);
        drive(0, 0, 1, 8'h01, F);
        drive(0, 0, 1, 8'h12, F);
        for (int k = 0; k < 64; k++) begin
            drive(0, 0, 0, 8'h00, F);
        end
        n_applied++;
        if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 ||
            mem_we !== 1'b0 || mem_addr !== 14'd0 || word_count !== 15'd0) begin
            n_miscompares++;
            $display("FAIL expired-wait: hold=%b done=%b err=%b we=%b addr=%h wc=%0d",
                     cpu_hold, load_done, load_err, mem_we, mem_addr, word_count);
        end else begin
            $display("expired-wait ok: hold=%b done=%b err=%b addr=%h wc=%0d",
                     cpu_hold, load_done, load_err, mem_addr, word_count);
        end
        drive(1, 0, 0, 8'h00, F);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
